// File: rtl/dlc_pkg.sv
// Shared types for the delay-chain measurement controller: FSM state encoding
// and the counter-width sizing helper used by the elaboration checks.
package dlc_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } dlc_state_e;

    // Smallest width whose all-ones value still covers both the timeout count
    // and the last flush count (DEPTH), plus headroom for the saturation value.
    function automatic int dlc_min_cnt_w(input int depth, input int timeout);
        int span;
        span = (timeout > depth + 1) ? timeout : depth + 1;
        return $clog2(span + 1);
    endfunction

endpackage

// File: rtl/dlc_cycle_counter.sv
// Saturating up-counter with synchronous clear and enable; shared by the
// flush-length and token-latency phases of delay_chain_ctrl.
module dlc_cycle_counter #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear wins over enable; the count parks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/delay_chain_ctrl.sv
// Delay-chain latency sequencer: flush, launch one token, time its arrival.
// Optional stuck-high detection at the end of flush is built with DLC_STUCK_CHECK_EN.
module delay_chain_ctrl
    import dlc_pkg::*;
#(
    parameter int DEPTH   = 240,
    parameter int TIMEOUT = 511,
    parameter int CNT_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pipe_out,
    output logic             pipe_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             stuck,
    output logic [CNT_W-1:0] measured,
    output dlc_state_e       fsm_state
);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    if (DEPTH < 1) begin : g_bad_depth
        $error("delay_chain_ctrl: DEPTH must be at least 1");
    end
    if (TIMEOUT <= DEPTH) begin : g_bad_timeout
        $error("delay_chain_ctrl: TIMEOUT must exceed DEPTH");
    end
    if (CNT_W < dlc_min_cnt_w(DEPTH, TIMEOUT)) begin : g_bad_width
        $error("delay_chain_ctrl: CNT_W too small for DEPTH/TIMEOUT");
    end

    dlc_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             flush_last;
    logic             cnt_clr;
    logic             cnt_en;

    // Handshake: start is a level request consumed only while idle; done is a
    // single-cycle pulse and the result outputs are valid from that cycle until
    // the next accepted start clears them.
    assign fsm_state  = state;
    assign flush_last = (state == S_FLUSH) && (cnt == DEPTH_C);
    assign cnt_clr    = (state == S_IDLE) || (state == S_DONE) || flush_last;
    assign cnt_en     = !cnt_clr;

    dlc_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt)
    );

`ifdef DLC_STUCK_CHECK_EN
    logic stuck_r;
    assign stuck = stuck_r;
`else
    assign stuck = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pipe_in  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            measured <= '0;
`ifdef DLC_STUCK_CHECK_EN
            stuck_r  <= 1'b0;
`endif
        end else begin
            pipe_in <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FLUSH;
                        busy     <= 1'b1;
                        pass     <= 1'b0;
                        timeout  <= 1'b0;
                        measured <= '0;
`ifdef DLC_STUCK_CHECK_EN
                        stuck_r  <= 1'b0;
`endif
                    end
                end
                S_FLUSH: begin
                    if (cnt == DEPTH_C) begin
`ifdef DLC_STUCK_CHECK_EN
                        // After DEPTH+1 zero cycles any high output means a stuck stage.
                        if (pipe_out) begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            stuck_r  <= 1'b1;
                            measured <= '0;
                        end else begin
                            state   <= S_LAUNCH;
                            pipe_in <= 1'b1;
                        end
`else
                        state   <= S_LAUNCH;
                        pipe_in <= 1'b1;
`endif
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Arrival is checked first so it beats a simultaneous timeout.
                    if (pipe_out) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        measured <= cnt;
                        pass     <= (cnt == DEPTH_C);
                    end else if (cnt == TIMEOUT_C) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        measured <= TIMEOUT_C;
                        pass     <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_chain_ctrl.sv
// Bench for delay_chain_ctrl with a behavioural chain and result model;
// expectations follow DLC_STUCK_CHECK_EN when the design is built with it.
module tb_delay_chain_ctrl;
    import dlc_pkg::*;

    localparam int DEPTH   = 240;
    localparam int TIMEOUT = 511;
    localparam int CNT_W   = 9;

    localparam int M_CHAIN = 0;
    localparam int M_TIE0  = 1;
    localparam int M_TIE1  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             pipe_out;
    logic             pipe_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic             stuck;
    logic [CNT_W-1:0] measured;
    dlc_state_e       fsm_state;

    delay_chain_ctrl #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pipe_out  (pipe_out),
        .pipe_in   (pipe_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .stuck     (stuck),
        .measured  (measured),
        .fsm_state (fsm_state)
    );

    // clock / cycle bookkeeping
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // chain model: chain_len register stages, or the output tied low/high
    int           chain_mode = M_CHAIN;
    int           chain_len  = DEPTH;
    logic [255:0] sr = '0;
    always @(posedge clk) sr <= {sr[254:0], pipe_in};
    assign pipe_out = (chain_mode == M_TIE0) ? 1'b0 :
                      (chain_mode == M_TIE1) ? 1'b1 : sr[chain_len-1];

    int launches   = 0;
    int launch_cyc = -1;
    always @(posedge clk) begin
        if (pipe_in === 1'b1) begin
            launches   <= launches + 1;
            launch_cyc <= cyc;
        end
    end

    // scoreboard
    typedef struct {
        int measured;
        int timeout;
        int stuck;
        int pass;
        int done_off;
        int launch_off;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Result of one measurement as offsets from the start-sample cycle S;
    // launch is at S+DEPTH+2, done one cycle after the deciding WAIT cycle.
    function automatic exp_t model(input int mode, input int d);
        exp_t e;
        int   l_off;
        l_off        = DEPTH + 2;
        e.timeout    = 0;
        e.stuck      = 0;
        e.launch_off = l_off;
        if (mode == M_CHAIN) begin
            e.measured = d;
            e.done_off = l_off + d + 1;
        end else if (mode == M_TIE0) begin
            e.measured = TIMEOUT;
            e.timeout  = 1;
            e.done_off = l_off + TIMEOUT + 1;
        end else begin
`ifdef DLC_STUCK_CHECK_EN
            e.measured   = 0;
            e.stuck      = 1;
            e.done_off   = DEPTH + 2;
            e.launch_off = -1;
`else
            e.measured = 1;
            e.done_off = l_off + 2;
`endif
        end
        e.pass = (e.measured == DEPTH && e.timeout == 0 && e.stuck == 0) ? 1 : 0;
        return e;
    endfunction

    // driver: one measurement, optionally with start pulses while busy
    task automatic run(input int mode, input int d, input bit spurious);
        int   s;
        int   l0;
        bit   got;
        exp_t e;
        chain_mode = mode;
        chain_len  = d;
        @(negedge clk);
        check("idle_before_start", fsm_state, S_IDLE);
        s     = cyc;
        l0    = launches;
        start = 1'b1;
        exp_q.push_back(model(mode, d));
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("flush_state", fsm_state, S_FLUSH);
        check("clr_measured", measured, 0);
        check("clr_pass", pass, 0);
        check("clr_timeout", timeout, 0);
        check("clr_stuck", stuck, 0);
        got = 1'b0;
        for (int i = 0; i < 1200 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got   = 1'b1;
                start = 1'b0;
            end else begin
                start = (spurious && busy === 1'b1 && $urandom_range(0, 15) == 0);
            end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        if (!got) begin
            check("done_seen", 0, 1);
        end else begin
            check("done_latency", cyc - s, e.done_off);
            check("measured", measured, e.measured);
            check("timeout", timeout, e.timeout);
            check("stuck", stuck, e.stuck);
            check("pass", pass, e.pass);
            check("busy_in_done", busy, 0);
            if (e.launch_off >= 0) begin
                check("launch_count", launches - l0, 1);
                check("launch_cycle", launch_cyc - s, e.launch_off);
            end else begin
                check("no_launch", launches - l0, 0);
            end
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("idle_after_done", fsm_state, S_IDLE);
            check("measured_hold", measured, e.measured);
            check("pass_hold", pass, e.pass);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, fsm_state, S_IDLE);
        check({tag, "_outs"}, {pipe_in, busy, done, pass, timeout, stuck}, 0);
        check({tag, "_measured"}, measured, 0);
    endtask

    initial begin
        int mode;
        int d;
        int s;
        int l0;
        int dn;
        int last_done;
        int done_at[3];

        // reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");
        check("no_launch_after_reset", launches, 0);

        // directed cases
        run(M_CHAIN, DEPTH, 1'b0);
        run(M_CHAIN, DEPTH - 1, 1'b0);
        run(M_TIE0, DEPTH, 1'b0);
        run(M_TIE1, DEPTH, 1'b0);

        // randomized chains and busy-time start pulses
        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            mode = ($urandom_range(0, 9) < 7) ? M_CHAIN : int'($urandom_range(1, 2));
            d    = int'($urandom_range(1, DEPTH + 1));
            run(mode, d, 1'b1);
        end

        // one-cycle reset in the middle of WAIT
        chain_mode = M_CHAIN;
        chain_len  = DEPTH;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 400 && fsm_state !== S_WAIT; i++) @(negedge clk);
        check("reached_wait", fsm_state, S_WAIT);
        repeat (10) @(negedge clk);
        l0    = launches;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("mid_wait_reset");
        @(negedge clk);
        check_all_zero("after_mid_wait_reset");
        check("no_launch_post_reset", launches - l0, 0);
        run(M_CHAIN, DEPTH, 1'b1);

        // start held high: three back-to-back measurements
        chain_mode = M_CHAIN;
        chain_len  = DEPTH;
        @(negedge clk);
        s         = cyc;
        start     = 1'b1;
        dn        = 0;
        last_done = -10;
        for (int i = 0; i < 1600 && dn < 3; i++) begin
            @(negedge clk);
            if (cyc == last_done + 1) begin
                check("b2b_hold_measured", measured, DEPTH);
                check("b2b_idle", fsm_state, S_IDLE);
            end
            if (cyc == last_done + 2) begin
                check("b2b_clear_measured", measured, 0);
                check("b2b_clear_pass", pass, 0);
            end
            if (done === 1'b1) begin
                done_at[dn] = cyc;
                check("b2b_measured", measured, DEPTH);
                check("b2b_pass", pass, 1);
                last_done = cyc;
                dn++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", dn, 3);
        if (dn == 3) begin
            check("b2b_first_done", done_at[0] - s, 2 * DEPTH + 3);
            check("b2b_spacing_1", done_at[1] - done_at[0], 2 * DEPTH + 4);
            check("b2b_spacing_2", done_at[2] - done_at[1], 2 * DEPTH + 4);
        end
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
